// File: rtl/multdiv_sequencer_pkg.sv
// multdiv_sequencer_pkg
//   Shared definitions for the multdiv sequencer and its cycle counter:
//   FSM state encoding, the $rstatus register index and the default
//   timeout budget / exception codes used as parameter defaults.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  // BUSY-state budget; the multdiv unit nominally needs 33 cycles.
  localparam int unsigned MAX_CYCLES_DEF  = 40;
  localparam int unsigned EXC_MULT_DEF    = 4;
  localparam int unsigned EXC_DIV_DEF     = 5;
  localparam int unsigned EXC_TIMEOUT_DEF = 6;

endpackage

// File: rtl/multdiv_sequencer_counter.sv
// md_cycle_counter
//   6-bit cycle counter used to bound the time spent waiting on multdiv.
//   Ports:
//     clock      - rising-edge clock
//     reset      - asynchronous active-low reset (count returns to 0)
//     clear_i    - synchronous clear, takes priority over enable_i
//     enable_i   - increment by one this cycle
//     terminal_o - count has reached MAX_CYCLES-1
module md_cycle_counter
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  logic [5:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 6'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == 6'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Runs one MULT/DIV on the shared multdiv unit for the X stage: captures
//   operands and destination, pulses start, stalls the front of the pipe
//   until the result (or a timeout) arrives, then emits a one-cycle
//   writeback record to rd, or an exception code to $rstatus (r30).
//   Ports:
//     clock, reset               - clock and async active-low reset
//     ctrl_MULT, ctrl_DIV        - X-stage decode (level)
//     opA, opB, rd_in            - operands / destination of the X instruction
//     flush                      - kill the X instruction, abort in-flight op
//     md_resultRDY/exception/result - multdiv completion handshake
//     md_start_mult/div, md_A/B  - multdiv start pulses and held operands
//     stall                      - freeze PC, F/D and D/X
//     wb_valid, wb_rd, wb_data   - single-cycle writeback record
//     busy                       - sequencer not idle
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned MAX_CYCLES  = MAX_CYCLES_DEF,
  parameter int unsigned EXC_MULT    = EXC_MULT_DEF,
  parameter int unsigned EXC_DIV     = EXC_DIV_DEF,
  parameter int unsigned EXC_TIMEOUT = EXC_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        op_q, op_d;            // 1 = multiply, 0 = divide
  logic [31:0] mdA_q, mdA_d;
  logic [31:0] mdB_q, mdB_d;
  logic [4:0]  rdL_q, rdL_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        timeout_q, timeout_d;

  logic req;
  logic cntClear, cntEnable, cntTerminal;

  // Reset is folded into req so that stall is also 0 while reset is held,
  // even if a MULT/DIV is sitting in X at that moment.
  assign req = (ctrl_MULT | ctrl_DIV) & ~flush & reset;

  md_cycle_counter #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cntClear),
    .enable_i   (cntEnable),
    .terminal_o (cntTerminal)
  );

  // Next-state, capture and stall. Flush in ISSUE/BUSY drops stall in the
  // same cycle and returns to IDLE, discarding any completion that follows.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mdA_d     = mdA_q;
    mdB_d     = mdB_q;
    rdL_d     = rdL_q;
    result_d  = result_q;
    exc_d     = exc_q;
    timeout_d = timeout_q;
    stall     = 1'b0;
    cntClear  = 1'b0;
    cntEnable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req) begin
          mdA_d   = opA;
          mdB_d   = opB;
          rdL_d   = rd_in;
          op_d    = ctrl_MULT;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cntClear = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall     = 1'b1;
          cntEnable = 1'b1;
          // A completion on the last budgeted cycle still wins over timeout.
          if (md_resultRDY) begin
            result_d  = md_result;
            exc_d     = md_exception;
            timeout_d = 1'b0;
            state_d   = ST_DONE;
          end else if (cntTerminal) begin
            exc_d     = 1'b0;
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      mdA_q     <= '0;
      mdB_q     <= '0;
      rdL_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mdA_q     <= mdA_d;
      mdB_q     <= mdB_d;
      rdL_q     <= rdL_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
    end
  end

  assign md_start_mult = (state_q == ST_ISSUE) &  op_q;
  assign md_start_div  = (state_q == ST_ISSUE) & ~op_q;
  assign md_A          = mdA_q;
  assign md_B          = mdB_q;
  assign busy          = (state_q != ST_IDLE);
  assign wb_valid      = (state_q == ST_DONE) & ~flush;

  // Writeback record: timeout beats the captured exception flag (they are
  // mutually exclusive anyway); fields are zero outside a valid record.
  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (wb_valid) begin
      if (timeout_q) begin
        wb_rd   = RSTATUS_REG;
        wb_data = 32'(EXC_TIMEOUT);
      end else if (exc_q) begin
        wb_rd   = RSTATUS_REG;
        wb_data = op_q ? 32'(EXC_MULT) : 32'(EXC_DIV);
      end else begin
        wb_rd   = rdL_q;
        wb_data = result_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
//   Directed and randomized bench for multdiv_sequencer. A transaction-level
//   model predicts, per cycle relative to the accept cycle, stall, busy,
//   start pulses, held operands and the writeback record.
module tb_multdiv_sequencer;

  localparam int MAXC = 40;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] opA, opB;
  logic [4:0]  rd_in;
  logic        flush;
  logic        md_resultRDY, md_exception;
  logic [31:0] md_result;
  logic        md_start_mult, md_start_div;
  logic [31:0] md_A, md_B;
  logic        stall, wb_valid, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks;
  int failures;

  multdiv_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .opA           (opA),
    .opB           (opB),
    .rd_in         (rd_in),
    .flush         (flush),
    .md_resultRDY  (md_resultRDY),
    .md_exception  (md_exception),
    .md_result     (md_result),
    .md_start_mult (md_start_mult),
    .md_start_div  (md_start_div),
    .md_A          (md_A),
    .md_B          (md_B),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .busy          (busy)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " start_mult"}, {31'd0, md_start_mult}, 32'd0);
    checkOutput({tag, " start_div"}, {31'd0, md_start_div}, 32'd0);
    checkOutput({tag, " md_A"}, md_A, 32'd0);
    checkOutput({tag, " md_B"}, md_B, 32'd0);
    checkOutput({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
    checkOutput({tag, " wb_rd"}, {27'd0, wb_rd}, 32'd0);
    checkOutput({tag, " wb_data"}, wb_data, 32'd0);
  endtask

  // One instruction from accept (k=0) to DONE or flush, then 'tail' idle
  // cycles. opSel: 0=DIV, 1=MULT, 2=both decoded (MULT expected).
  // lat: cycles from start pulse to RDY (1..MAXC), 0 = RDY never comes.
  // flushAt: cycle index (>=2) at which flush is driven, 0 = never.
  // Entered and left at posedge+1.
  task automatic applyStimulus(input string name, input int opSel,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int lat,
                               input bit exc, input logic [31:0] res,
                               input int flushAt, input bit spur, input int tail);
    bit          isMult, timedOut, flushing, realRdy;
    int          doneCyc, lastCyc;
    logic [4:0]  expRd;
    logic [31:0] expData;

    isMult   = (opSel != 0);
    timedOut = (lat < 1) || (lat > MAXC);
    doneCyc  = timedOut ? MAXC + 2 : lat + 2;
    if (timedOut) begin
      expRd = 5'd30; expData = 32'd6;
    end else if (exc) begin
      expRd = 5'd30; expData = isMult ? 32'd4 : 32'd5;
    end else begin
      expRd = rd; expData = res;
    end
    lastCyc = (flushAt > 0 && flushAt < doneCyc) ? flushAt : doneCyc;

    for (int k = 0; k <= lastCyc; k++) begin
      flushing     = (flushAt > 0) && (k == flushAt);
      realRdy      = !timedOut && (k == lat + 1);
      ctrl_MULT    = (opSel != 0);
      ctrl_DIV     = (opSel != 1);
      opA          = (k == 0) ? a : $urandom();
      opB          = (k == 0) ? b : $urandom();
      rd_in        = (k == 0) ? rd : 5'($urandom());
      flush        = flushing;
      md_resultRDY = realRdy || (spur && k == 1);
      md_result    = realRdy ? res : $urandom();
      md_exception = realRdy ? exc : 1'($urandom());
      @(negedge clock);
      checkOutput($sformatf("%s k=%0d stall", name, k), {31'd0, stall},
                  {31'd0, (k < doneCyc) && !flushing});
      checkOutput($sformatf("%s k=%0d busy", name, k), {31'd0, busy}, {31'd0, k >= 1});
      checkOutput($sformatf("%s k=%0d start_mult", name, k), {31'd0, md_start_mult},
                  {31'd0, (k == 1) && isMult});
      checkOutput($sformatf("%s k=%0d start_div", name, k), {31'd0, md_start_div},
                  {31'd0, (k == 1) && !isMult});
      checkOutput($sformatf("%s k=%0d wb_valid", name, k), {31'd0, wb_valid},
                  {31'd0, (k == doneCyc) && !flushing});
      if (k >= 1) begin
        checkOutput($sformatf("%s k=%0d md_A", name, k), md_A, a);
        checkOutput($sformatf("%s k=%0d md_B", name, k), md_B, b);
      end
      if (k == doneCyc && !flushing) begin
        checkOutput($sformatf("%s wb_rd", name), {27'd0, wb_rd}, {27'd0, expRd});
        checkOutput($sformatf("%s wb_data", name), wb_data, expData);
      end
      @(posedge clock); #1;
    end

    for (int k = lastCyc + 1; k <= lastCyc + tail; k++) begin
      realRdy      = !timedOut && (k == lat + 1);
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      flush        = 1'b0;
      md_resultRDY = realRdy;
      md_result    = $urandom();
      md_exception = 1'($urandom());
      @(negedge clock);
      checkOutput($sformatf("%s idle k=%0d stall", name, k), {31'd0, stall}, 32'd0);
      checkOutput($sformatf("%s idle k=%0d busy", name, k), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("%s idle k=%0d wb_valid", name, k), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("%s idle k=%0d start", name, k),
                  {31'd0, md_start_mult | md_start_div}, 32'd0);
      @(posedge clock); #1;
    end

    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    flush        = 1'b0;
    md_resultRDY = 1'b0;
  endtask

  initial begin
    clock        = 1'b0;
    reset        = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    opA          = '0;
    opB          = '0;
    rd_in        = '0;
    flush        = 1'b0;
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;
    checks       = 0;
    failures     = 0;

    // Power-on reset state
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    // MULT 7*6 -> r3, RDY 33 cycles after start
    applyStimulus("mult42", 1, 32'd7, 32'd6, 5'd3, 33, 1'b0, 32'd42, 0, 1'b0, 2);

    // DIV by zero -> $rstatus = 5
    applyStimulus("divzero", 0, 32'd100, 32'd0, 5'd9, 33, 1'b1, $urandom(), 0, 1'b0, 2);

    // MULT that never completes -> timeout after 40 BUSY cycles
    applyStimulus("timeout", 1, $urandom(), $urandom(), 5'd12, 0, 1'b0, 32'd0, 0, 1'b0, 2);

    // Flush on BUSY cycle 10, late RDY on cycle 33 must be ignored
    applyStimulus("flushbusy", 1, $urandom(), $urandom(), 5'd4, 33, 1'b0, $urandom(), 11, 1'b0, 25);

    // Reset mid-BUSY: outputs clear before the next edge
    ctrl_MULT = 1'b1;
    opA       = 32'hDEAD_BEEF;
    opB       = 32'h1234_5678;
    rd_in     = 5'd7;
    repeat (12) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    checkOutput("midbusy busy", {31'd0, busy}, 32'd1);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    #1;
    checkAllZero("async reset");
    @(posedge clock); #1;
    checkAllZero("held reset");
    reset = 1'b1;
    applyStimulus("afterreset", 1, $urandom(), $urandom(), 5'd17, 20, 1'b0, $urandom(), 0, 1'b0, 1);

    // Back-to-back MULT then DIV, second accepted in the cycle after DONE
    applyStimulus("b2b_mult", 1, $urandom(), $urandom(), 5'd5, 10, 1'b0, 32'hAAAA_0001, 0, 1'b0, 0);
    applyStimulus("b2b_div", 0, $urandom(), $urandom(), 5'd6, 12, 1'b0, 32'h5555_0002, 0, 1'b0, 2);

    // Both decodes high (MULT wins), with a spurious RDY in the ISSUE cycle
    applyStimulus("both_spur", 2, $urandom(), $urandom(), 5'd21, 5, 1'b0, $urandom(), 0, 1'b1, 1);

    // RDY on the final budgeted cycle beats the timeout
    applyStimulus("rdy_at_limit", 0, $urandom(), $urandom(), 5'd8, MAXC, 1'b0, 32'h0BAD_F00D, 0, 1'b0, 1);

    // MULT overflow exception -> $rstatus = 4
    applyStimulus("multovf", 1, $urandom(), $urandom(), 5'd2, 15, 1'b1, $urandom(), 0, 1'b0, 1);

    // rd = r0 still produces a valid writeback record
    applyStimulus("rd_zero", 1, $urandom(), $urandom(), 5'd0, 8, 1'b0, 32'h0000_0099, 0, 1'b0, 1);

    // Flush in the DONE cycle suppresses the record
    applyStimulus("flushdone", 0, $urandom(), $urandom(), 5'd11, 6, 1'b0, $urandom(), 8, 1'b0, 2);

    // Flush in IDLE suppresses the request
    ctrl_DIV = 1'b1;
    flush    = 1'b1;
    @(negedge clock);
    checkOutput("idleflush stall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    flush    = 1'b0;
    @(negedge clock);
    checkOutput("idleflush busy", {31'd0, busy}, 32'd0);
    checkOutput("idleflush start", {31'd0, md_start_mult | md_start_div}, 32'd0);
    @(posedge clock); #1;

    // Randomized transactions
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rand%0d", i), int'($urandom_range(0, 2)), $urandom(), $urandom(),
                    5'($urandom()), int'($urandom_range(1, MAXC)), 1'($urandom()), $urandom(),
                    0, 1'($urandom()), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Sequences the shared multi-cycle multiplier/divider on behalf of the execute stage. When the X-stage control decodes MULT or DIV, this block captures the operands and destination. It then issues a one-cycle start pulse to the multdiv unit and stalls the front of the pipeline until the result is ready or a timeout fires. Finally it presents a single-cycle writeback record: the product/quotient to $rd, or an exception code to $rstatus (r30).

Parameters:
MAX_CYCLES, 40, BUSY-state cycle budget before forced timeout (multdiv nominally needs 33).
EXC_MULT, 4, $rstatus value on multiply overflow.
EXC_DIV, 5, $rstatus value on divide-by-zero.
EXC_TIMEOUT, 6, $rstatus value on timeout.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
ctrl_MULT  in  1  X-stage decode: MULT in X (level).
ctrl_DIV  in  1  X-stage decode: DIV in X (level).
opA  in  32  $rs value in X (post-bypass).
opB  in  32  $rt value in X (post-bypass).
rd_in  in  5  destination register of the X instruction.
flush  in  1  kill the instruction in X; abort any in-flight op.
md_resultRDY  in  1  multdiv result valid (pulse).
md_exception  in  1  multdiv exception, qualified by md_resultRDY.
md_result  in  32  multdiv result, qualified by md_resultRDY.
md_start_mult  out  1  one-cycle start-multiply pulse.
md_start_div  out  1  one-cycle start-divide pulse.
md_A  out  32  latched operand A held for multdiv.
md_B  out  32  latched operand B held for multdiv.
stall  out  1  freeze PC, F/D and D/X latches.
wb_valid  out  1  writeback record valid for one cycle.
wb_rd  out  5  writeback register: rd, or 30 on exception.
wb_data  out  32  result, or exception code.
busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, ISSUE, BUSY, DONE, encoded in 2 bits.
- Reset (reset=0, asynchronous): state=IDLE, counter=0, op=0. All outputs and latched registers are 0, regardless of what the state was before reset.
- IDLE:
  - Let req = (ctrl_MULT|ctrl_DIV) & ~flush.
  - On req: latch opA→md_A, opB→md_B, rd_in→rd_l, op←ctrl_MULT (MULT wins if both are set); go to ISSUE.
  - stall = req, combinational in the same cycle, so the instruction holds in X.
- ISSUE:
  - stall=1; exactly one of md_start_mult/md_start_div = 1, selected by op.
  - Counter cleared. md_resultRDY is ignored in this cycle.
  - Next state: BUSY.
- BUSY:
  - stall=1; counter increments each cycle.
  - md_resultRDY=1: capture result and exception; go to DONE.
  - Else if counter==MAX_CYCLES-1: record a timeout; go to DONE.
  - md_resultRDY has priority over timeout in the same cycle.
- DONE:
  - stall=0, so the X instruction advances this edge; wb_valid=1 for exactly this cycle.
  - No exception: wb_rd=rd_l, wb_data=result.
  - Exception: wb_rd=30, wb_data=EXC_MULT or EXC_DIV by op.
  - Timeout: wb_rd=30, wb_data=EXC_TIMEOUT.
  - rd_l=0 with no exception: wb_valid still 1; the regfile discards writes to r0.
  - ctrl_* is still high this cycle and must not retrigger. Next state: IDLE.
- Back-to-back: a MULT/DIV entering X in the cycle after DONE is accepted in IDLE, giving minimum issue spacing of 1 idle cycle.
- flush:
  - In IDLE: suppresses req.
  - In ISSUE/BUSY: go to IDLE next edge; no writeback; stall drops immediately (combinational); a late md_resultRDY is ignored.
  - In DONE: wb_valid is forced 0.
- Latency: the stall covers the IDLE accept cycle, the ISSUE cycle and all BUSY cycles. With a multdiv latency of N cycles after the start pulse, DONE falls on cycle N+2 after accept.
- md_A/md_B stay stable from ISSUE through DONE.
- Outputs wb_* and md_start_* are registered from state, except stall and the DONE-cycle flush qualification.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_BUSY=2'd2, ST_DONE=2'd3), RSTATUS_REG=5'd30, and the exception-code defaults.
- One sub-module: md_cycle_counter, a 6-bit counter with synchronous clear/enable, asynchronous active-low reset and a terminal-count compare against MAX_CYCLES-1.

Test Plan:
- MULT opA=7, opB=6, rd=3; multdiv returns RDY 33 cycles after start with result 42 → one start_mult pulse; stall high for 35 cycles; wb_valid pulse with wb_rd=3, wb_data=42.
- DIV opB=0; multdiv returns RDY with exception=1 → wb_rd=30, wb_data=5; md_start_div was the only start pulse.
- MULT whose RDY never arrives → timeout after 40 BUSY cycles; wb_rd=30, wb_data=6; stall drops in the DONE cycle.
- flush asserted on BUSY cycle 10, RDY later on cycle 33 → state IDLE after one edge; wb_valid stays 0; late RDY ignored.
- reset driven low mid-BUSY → all outputs 0 immediately, before the next clock; the next MULT after release completes normally.
- Back-to-back MULT then DIV (ctrl_DIV high in the cycle after DONE) → second op accepted, with exactly one IDLE cycle between the two DONE-to-ISSUE sequences and two distinct wb pulses in order.
